// File: rtl/f_fetch_stage.sv
// F-stage PC register and F/D pipeline register for the 5-stage MIPS pipeline.
// Flags fetch address errors and delay-slot instructions, and handles stall, flush and eret squash.
module f_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter logic [31:0] INT_PC   = 32'h0000_4180,
    parameter logic [31:0] PC_LO    = 32'h0000_3000,
    parameter logic [31:0] PC_HI    = 32'h0000_6ffc,
    parameter logic [4:0]  EXC_ADEL = 5'd4
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [31:0] i_npc,
    input  logic        i_stall,
    input  logic        i_Req,
    input  logic        i_eret,
    input  logic        i_D_isJump,
    input  logic [31:0] i_imData,
    output logic [31:0] o_imAddr,
    output logic [31:0] o_F_pc,
    output logic [4:0]  o_F_excCode,
    output logic        o_F_bd,
    output logic [31:0] o_D_pc,
    output logic [31:0] o_D_instr,
    output logic [4:0]  o_D_excCode,
    output logic        o_D_bd
);
    localparam int unsigned XLEN  = 32;
    localparam int unsigned EXC_W = 5;

    logic [XLEN-1:0] f_pc;
    logic            adel;
    logic [XLEN-1:0] f_instr;

    // Fetch address error: misaligned or outside the instruction window.
    always_comb begin
        adel    = (f_pc[1:0] != 2'b00) || (f_pc < PC_LO) || (f_pc > PC_HI);
        f_instr = adel ? XLEN'(0) : i_imData;
    end

    assign o_imAddr    = f_pc;
    assign o_F_pc      = f_pc;
    assign o_F_excCode = adel ? EXC_ADEL : EXC_W'(0);
    assign o_F_bd      = i_D_isJump;

    // PC register: a flush redirects to the handler even while stalled.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            f_pc <= RESET_PC;
        end else if (i_Req) begin
            f_pc <= INT_PC;
        end else if (!i_stall) begin
            f_pc <= i_npc;
        end
    end

    // F/D register: flush bubble carries INT_PC, eret bubble carries 0.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_D_pc      <= XLEN'(0);
            o_D_instr   <= XLEN'(0);
            o_D_excCode <= EXC_W'(0);
            o_D_bd      <= 1'b0;
        end else if (i_Req) begin
            o_D_pc      <= INT_PC;
            o_D_instr   <= XLEN'(0);
            o_D_excCode <= EXC_W'(0);
            o_D_bd      <= 1'b0;
        end else if (i_stall) begin
            o_D_pc      <= o_D_pc;
            o_D_instr   <= o_D_instr;
            o_D_excCode <= o_D_excCode;
            o_D_bd      <= o_D_bd;
        end else if (i_eret) begin
            o_D_pc      <= XLEN'(0);
            o_D_instr   <= XLEN'(0);
            o_D_excCode <= EXC_W'(0);
            o_D_bd      <= 1'b0;
        end else begin
            o_D_pc      <= f_pc;
            o_D_instr   <= f_instr;
            o_D_excCode <= o_F_excCode;
            o_D_bd      <= i_D_isJump;
        end
    end
endmodule

// File: tb/tb_f_fetch_stage.sv
// Scoreboard bench for f_fetch_stage: stimulus pushes expectations from a reference model,
// monitors pop and compare combinational outputs mid-cycle and registered outputs after each edge.
module tb_f_fetch_stage;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] npc;
    logic        stall, req, eret, jump;
    logic [31:0] imdata;
    logic [31:0] im_addr, f_pc_o, d_pc_o, d_instr_o;
    logic [4:0]  f_exc_o, d_exc_o;
    logic        f_bd_o, d_bd_o;

    typedef struct {
        logic [31:0] f_pc;
        logic [31:0] d_pc;
        logic [31:0] d_instr;
        logic [4:0]  d_exc;
        logic        d_bd;
    } reg_exp_t;

    typedef struct {
        logic [31:0] addr;
        logic [4:0]  exc;
        logic        bd;
    } comb_exp_t;

    reg_exp_t  reg_q[$];
    comb_exp_t comb_q[$];
    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [31:0] m_fpc, m_dpc, m_dinstr;
    logic [4:0]  m_dexc;
    logic        m_dbd;
    bit          m_valid = 0;

    always #5 clk = ~clk;

    f_fetch_stage dut (
        .i_clk(clk), .i_reset(rst), .i_npc(npc), .i_stall(stall), .i_Req(req),
        .i_eret(eret), .i_D_isJump(jump), .i_imData(imdata),
        .o_imAddr(im_addr), .o_F_pc(f_pc_o), .o_F_excCode(f_exc_o), .o_F_bd(f_bd_o),
        .o_D_pc(d_pc_o), .o_D_instr(d_instr_o), .o_D_excCode(d_exc_o), .o_D_bd(d_bd_o)
    );

    // Behavioural instruction memory: contents are a fixed function of the address.
    function automatic logic [31:0] imem(input logic [31:0] a);
        return {~a[15:0], a[15:0]} ^ 32'h1234_5678;
    endfunction

    assign imdata = imem(im_addr);

    function automatic bit fetch_bad(input logic [31:0] pc);
        return (pc % 4 != 0) || (pc < 32'h3000) || (pc > 32'h6ffc);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Apply one cycle of inputs and record what the DUT must show.
    task automatic drive(input bit r, input logic [31:0] n, input bit s, input bit q,
                         input bit e, input bit j);
        comb_exp_t c;
        reg_exp_t  x;
        bit        b;
        @(negedge clk);
        rst = r; npc = n; stall = s; req = q; eret = e; jump = j;
        if (m_valid && !r) begin
            b = fetch_bad(m_fpc);
            c.addr = m_fpc;
            c.exc  = b ? 5'd4 : 5'd0;
            c.bd   = j;
            comb_q.push_back(c);
            if (q) begin
                x = '{32'h4180, 32'h4180, 32'h0, 5'd0, 1'b0};
            end else if (s) begin
                x = '{m_fpc, m_dpc, m_dinstr, m_dexc, m_dbd};
            end else if (e) begin
                x = '{n, 32'h0, 32'h0, 5'd0, 1'b0};
            end else begin
                x = '{n, m_fpc, b ? 32'h0 : imem(m_fpc), c.exc, j};
            end
        end else begin
            x = '{32'h3000, 32'h0, 32'h0, 5'd0, 1'b0};
        end
        reg_q.push_back(x);
        m_fpc = x.f_pc; m_dpc = x.d_pc; m_dinstr = x.d_instr; m_dexc = x.d_exc; m_dbd = x.d_bd;
        m_valid = 1;
    endtask

    // Combinational monitor: mid low phase, after inputs have settled.
    initial begin
        comb_exp_t c;
        forever begin
            @(negedge clk);
            #2;
            if (comb_q.size() > 0) begin
                c = comb_q.pop_front();
                check("im_addr", im_addr, c.addr);
                check("f_exc", 32'(f_exc_o), 32'(c.exc));
                check("f_bd", 32'(f_bd_o), 32'(c.bd));
            end
        end
    end

    // Registered monitor: just after each rising edge.
    initial begin
        reg_exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (reg_q.size() > 0) begin
                x = reg_q.pop_front();
                check("f_pc", f_pc_o, x.f_pc);
                check("d_pc", d_pc_o, x.d_pc);
                check("d_instr", d_instr_o, x.d_instr);
                check("d_exc", 32'(d_exc_o), 32'(x.d_exc));
                check("d_bd", 32'(d_bd_o), 32'(x.d_bd));
            end
        end
    end

    function automatic logic [31:0] rand_npc();
        logic [31:0] edges [8];
        edges = '{32'h2ffc, 32'h3000, 32'h6ffc, 32'h7000, 32'h3002, 32'h4180, 32'hffff_fffc, 32'h0};
        case ($urandom % 8)
            0, 1, 2, 3: return 32'h3000 + 32'($urandom % 4096) * 4;
            4:          return m_fpc + 4;
            5:          return 32'h3000 + 32'($urandom % 4096) * 4 + 32'($urandom_range(1, 3));
            6:          return edges[$urandom % 8];
            default:    return $urandom;
        endcase
    endfunction

    initial begin
        int guard;
        rst = 1; npc = 0; stall = 0; req = 0; eret = 0; jump = 0;
        // Directed walk through the main scenarios
        drive(1, 0, 0, 0, 0, 0);
        repeat (3) drive(0, m_fpc + 4, 0, 0, 0, 0);
        repeat (2) drive(0, m_fpc + 4, 1, 0, 0, 0);
        drive(0, m_fpc + 4, 0, 0, 0, 0);
        drive(0, 32'h3010, 0, 0, 0, 0);
        drive(0, m_fpc + 4, 1, 1, 0, 0);
        drive(0, 32'h3002, 0, 0, 0, 0);
        drive(0, 32'h7000, 0, 0, 0, 0);
        drive(0, 32'h6ffc, 0, 0, 0, 0);
        drive(0, 32'h3020, 0, 0, 0, 0);
        drive(0, 32'h3024, 0, 0, 0, 1);
        drive(0, 32'h4190, 0, 0, 0, 0);
        drive(0, 32'h4194, 0, 0, 1, 0);
        drive(0, 32'h4198, 0, 0, 0, 0);
        drive(0, 32'h419c, 1, 0, 1, 0);
        drive(0, 32'h41a0, 0, 0, 1, 0);
        drive(1, 32'h5000, 1, 1, 1, 1);
        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            drive($urandom % 40 == 0, rand_npc(), $urandom % 4 == 0, $urandom % 12 == 0,
                  $urandom % 8 == 0, $urandom % 3 == 0);
        end
        drive(0, 32'h3000, 0, 0, 0, 0);
        guard = 0;
        while ((reg_q.size() > 0 || comb_q.size() > 0) && guard < 10) begin
            @(posedge clk);
            guard++;
        end
        repeat (2) @(posedge clk);
        total++;
        if (reg_q.size() != 0 || comb_q.size() != 0) begin
            bad++;
            $display("FAIL drain: reg_q=%0d comb_q=%0d expected 0", reg_q.size(), comb_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
